if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage. It generates the PC, fetches instructions over a request/grant/response instruction-memory interface, and presents pc/IR/valid plus a clear pulse to the IF_ID pipeline register. It honours the hazard unit's stall and the branch unit's redirect, and squashes any in-flight fetch on redirect. It is the producer side of the IF_ID interface; the IF_ID register is the consumer.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  32  fetch address; valid while imem_req=1
imem_gnt  in  1  request accepted this cycle (imem_req & imem_gnt)
imem_rvalid  in  1  response valid; earliest one cycle after grant
imem_rdata  in  32  instruction word, valid with imem_rvalid
stall  in  1  IF_ID holding; output not consumed this cycle
redirect  in  1  branch/jump taken
redirect_pc  in  32  new fetch target, sampled when redirect=1
if_pc  out  32  PC of presented instruction (to IF_ID pc)
if_ir  out  32  presented instruction (to IF_ID IR)
if_valid  out  1  if_pc/if_ir hold a live instruction
if_clear  out  1  bubble/flush to IF_ID (drives PCclear)

Behaviour:
- Reset (async, any state): state=IDLE, fetch_pc=RESET_PC, req_pc=0, if_pc=0, if_ir=0, if_valid=0, if_clear=0, imem_req=0. Any rvalid arriving after reset in IDLE is ignored.
- imem_addr = fetch_pc (combinational). At most one outstanding request.
- The output register is consumed in any cycle with if_valid=1 and stall=0. It is then cleared unless refilled in the same cycle.
- FSM:
  - IDLE:
    - imem_req=1 iff redirect=0 and (if_valid=0 or stall=0).
    - On req&gnt: req_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_STEP (mod 2^32), go to WAIT.
    - Without gnt, req stays asserted next cycle unless a redirect occurs. The address may change only while ungranted.
  - WAIT: imem_req=0. On rvalid: if_pc<=req_pc, if_ir<=imem_rdata, if_valid<=1, go to IDLE.
  - DROP: imem_req=0. On rvalid: discard data, go to IDLE.
- The issue rule guarantees the output register is empty when a response arrives; no data loss under stall.
- Throughput: one instruction per 2 cycles with a zero-wait memory (grant cycle, rvalid cycle).
- Redirect (any state, highest priority):
  - fetch_pc<=redirect_pc.
  - if_valid<=0.
  - if_clear=1 for exactly the next cycle. Back-to-back redirects hold if_clear high.
  - No imem_req is issued in the redirect cycle.
  - WAIT with no rvalid -> DROP. WAIT with rvalid in the same cycle -> response discarded, go to IDLE.
  - DROP -> stays in DROP (new target taken).
  - IDLE with req pending but ungranted -> request withdrawn, new address next cycle.
- stall and redirect together: redirect wins; output flushed.
- redirect_pc[1:0] is not checked; it is used as given.
- rvalid in IDLE (protocol violation) is ignored.

Optional Feature:
Macro: IF_PERF_CNT_EN
- Defined: adds outputs fetch_cnt[31:0] and squash_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - fetch_cnt increments on every response written to the output register.
  - squash_cnt increments on every discarded response and on every cycle in which redirect clears if_valid=1.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

Decomposition:
- Shared package if_pkg: state enum (IDLE, WAIT, DROP), XLEN=32, PC_STEP default.
- Natural sub-module: if_pc_gen, holding fetch_pc (reset, increment-on-grant, redirect load).
- FSM and output register stay in if_fetch_unit.

Test Plan:
- Reset release, memory grants immediately, rvalid 1 cycle later with rdata=pc^32'hA5A5_0000 -> imem_addr 0,4,8 in order; if_pc=0,4,8 with matching if_ir; if_valid pulses every 2 cycles.
- stall=1 for 5 cycles while if_valid=1 -> if_pc/if_ir stable; no imem_req issued; after stall drops, next request issues the same cycle.
- Redirect to 32'h0000_0100 while in WAIT, then rvalid with 32'hDEAD_BEEF -> data discarded; if_clear=1 for one cycle; next imem_addr=32'h100.
- Redirect the same cycle as rvalid -> response discarded, if_valid=0, FSM returns to IDLE; next fetch at redirect_pc.
- imem_gnt held low 3 cycles -> imem_req high with stable address; redirect mid-wait -> address switches to redirect_pc the cycle after.
- rst_n asserted in WAIT, late rvalid arrives after release -> ignored; first fetch at RESET_PC; with IF_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch stage: datapath width, default
// reset PC and sequential PC increment, and the fetch FSM state encoding.
// ----------------------------------------------------------------------------
package if_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP_DEFAULT  = 32'd4;

    // IDLE: may issue a request. WAIT: one request outstanding, response
    // wanted. DROP: one request outstanding, response to be thrown away.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_pc_gen.sv
// ----------------------------------------------------------------------------
// if_pc_gen
// Holds the next fetch address. Loads redirect_pc on a redirect, otherwise
// advances by PC_STEP (modulo 2^XLEN) each time a request is granted.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset (fetch_pc <= RESET_PC)
//   grant        fetch request accepted this cycle
//   redirect     branch/jump taken; loads redirect_pc
//   redirect_pc  new fetch target
//   fetch_pc     current fetch address
// ----------------------------------------------------------------------------
module if_pc_gen
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            grant,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] fetch_pc
);

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;

    // Redirect has priority; the fetch FSM never grants in a redirect cycle,
    // so the ordering only matters for robustness.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (grant) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign fetch_pc = fetch_pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage. Issues at most one outstanding request on the
// req/gnt/rvalid instruction-memory interface, presents pc/IR/valid to the
// IF_ID register, honours stall, and squashes in-flight fetches on redirect.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   imem_req/imem_addr          fetch request and address
//   imem_gnt                    request accepted this cycle
//   imem_rvalid/imem_rdata      response valid and instruction word
//   stall                       IF_ID holding; output not consumed
//   redirect/redirect_pc        branch/jump taken and its target
//   if_pc/if_ir/if_valid        presented instruction to IF_ID
//   if_clear                    one-cycle flush to IF_ID after a redirect
//
// Optional feature (macro IF_PERF_CNT_EN):
//   fetch_cnt   responses written to the output register
//   squash_cnt  discarded responses plus redirects that flushed a live output
// ----------------------------------------------------------------------------
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_ir,
    output logic            if_valid,
    output logic            if_clear
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     squash_cnt
`endif
);

    fetch_state_e    state_q,    state_d;
    logic [XLEN-1:0] req_pc_q,   req_pc_d;
    logic [XLEN-1:0] if_pc_q,    if_pc_d;
    logic [XLEN-1:0] if_ir_q,    if_ir_d;
    logic            if_valid_q, if_valid_d;
    logic            if_clear_q, if_clear_d;

    logic            issue_req;
    logic            load_resp;
    logic            grant;
    logic [XLEN-1:0] fetch_pc;

    if_pc_gen #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .grant       (grant),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_pc    (fetch_pc)
    );

    // Next-state and output logic. A request is only issued when the output
    // register is empty or being consumed this cycle, so a response can never
    // find it occupied. rst_n gates the request so nothing is asked for while
    // reset is held. In DROP, a redirect that coincides with the awaited
    // response still retires that response, otherwise nothing would ever
    // release the FSM.
    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        if_pc_d    = if_pc_q;
        if_ir_d    = if_ir_q;
        if_valid_d = if_valid_q & stall;
        if_clear_d = redirect;
        issue_req  = 1'b0;
        load_resp  = 1'b0;

        case (state_q)
            IDLE: begin
                issue_req = rst_n & ~redirect & (~if_valid_q | ~stall);
                if (issue_req && imem_gnt) begin
                    req_pc_d = fetch_pc;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d   = IDLE;
                    load_resp = ~redirect;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_resp) begin
            if_pc_d    = req_pc_q;
            if_ir_d    = imem_rdata;
            if_valid_d = 1'b1;
        end

        if (redirect) begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_pc_q   <= '0;
            if_pc_q    <= '0;
            if_ir_q    <= '0;
            if_valid_q <= 1'b0;
            if_clear_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            if_pc_q    <= if_pc_d;
            if_ir_q    <= if_ir_d;
            if_valid_q <= if_valid_d;
            if_clear_q <= if_clear_d;
        end
    end

    assign grant     = issue_req & imem_gnt;
    assign imem_req  = issue_req;
    assign imem_addr = fetch_pc;
    assign if_pc     = if_pc_q;
    assign if_ir     = if_ir_q;
    assign if_valid  = if_valid_q;
    assign if_clear  = if_clear_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q,  fetch_cnt_d;
    logic [31:0] squash_cnt_q, squash_cnt_d;
    logic        drop_resp;
    logic        flush_live;

    // A response is discarded when it lands in DROP or together with a
    // redirect in WAIT; stray responses in IDLE are not counted.
    always_comb begin
        drop_resp    = imem_rvalid & ((state_q == DROP) | ((state_q == WAIT) & redirect));
        flush_live   = redirect & if_valid_q;
        fetch_cnt_d  = fetch_cnt_q + {31'd0, load_resp};
        squash_cnt_d = squash_cnt_q + {31'd0, drop_resp} + {31'd0, flush_live};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit with a one-outstanding memory responder
// and a scoreboard of expected presented instructions.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        stall       = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] if_pc;
    logic [31:0] if_ir;
    logic        if_valid;
    logic        if_clear;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          pops     = 0;

    // Memory responder controls
    bit          gnt_en    = 1'b0;
    bit          hold_resp = 1'b0;
    bit          ovr_en    = 1'b0;
    logic [31:0] ovr_data  = 32'h0;

    // Reference model state
    bit          pend      = 1'b0;
    bit          pend_sq   = 1'b0;
    bit          pend_rst  = 1'b0;
    logic [31:0] pend_pc   = 32'h0;
    logic [31:0] exp_addr  = 32'h0;
    logic [63:0] exp_q[$];
    logic [31:0] held_pc   = 32'h0;
    logic [31:0] held_ir   = 32'h0;
    logic [31:0] fetch_exp  = 32'h0;
    logic [31:0] squash_exp = 32'h0;
    bit          prev_valid  = 1'b0;
    bit          prev_stall  = 1'b0;
    bit          prev_rd     = 1'b0;
    bit          pushed_last = 1'b0;
    bit          last_req    = 1'b0;
    logic [31:0] last_addr   = 32'h0;

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_pc       (if_pc),
        .if_ir       (if_ir),
        .if_valid    (if_valid),
        .if_clear    (if_clear)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .squash_cnt  (squash_cnt)
`endif
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Registered outputs, sampled at the falling edge: if_clear follows the
    // previous cycle's redirect, and each fresh presentation pops the scoreboard.
    task automatic checkOutput();
        logic [63:0] e;
        checkVal("if_clear_pulse", {31'd0, if_clear}, {31'd0, prev_rd});
        if (prev_rd) checkVal("flush_valid", {31'd0, if_valid}, 32'd0);
        if (pushed_last) checkVal("resp_to_output", {31'd0, if_valid}, 32'd1);
        if (if_valid && prev_valid && prev_stall) begin
            checkVal("stall_hold_pc", if_pc, held_pc);
            checkVal("stall_hold_ir", if_ir, held_ir);
        end else if (if_valid) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("[TB] FAIL unexpected_output observed pc=%h expected=no output", if_pc);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                pops++;
                held_pc = e[63:32];
                held_ir = e[31:0];
                checkVal("out_pc", if_pc, held_pc);
                checkVal("out_ir", if_ir, held_ir);
            end
        end
        prev_valid  = if_valid;
        pushed_last = 1'b0;
    endtask

    // One clock cycle: check outputs, drive inputs plus the memory responder,
    // then check the combinational request against the address model.
    task automatic applyStimulus(input bit st, input bit rd, input logic [31:0] rpc);
        bit deliver;
        bit granted;
        @(negedge clk);
        checkOutput();
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        deliver     = pend && !hold_resp;
        imem_rvalid = deliver;
        imem_rdata  = ovr_en ? ovr_data : (deliver ? (pend_pc ^ 32'hA5A5_0000) : 32'h0);
        imem_gnt    = gnt_en;
        #1;
        last_req  = imem_req;
        last_addr = imem_addr;
        granted   = imem_req && imem_gnt;
        if (rd) checkVal("no_req_on_redirect", {31'd0, imem_req}, 32'd0);
        if (st && if_valid) checkVal("no_req_while_stalled", {31'd0, imem_req}, 32'd0);
        if (pend && !pend_rst) checkVal("one_outstanding", {31'd0, imem_req}, 32'd0);
        if (imem_req) checkVal("req_addr", imem_addr, exp_addr);
        if (granted) exp_addr = exp_addr + 32'd4;
        if (rd) begin
            exp_addr = rpc;
            if (if_valid) squash_exp = squash_exp + 32'd1;
        end
        if (deliver) begin
            pend = 1'b0;
            if (!pend_rst) begin
                if (pend_sq || rd) begin
                    squash_exp = squash_exp + 32'd1;
                end else begin
                    exp_q.push_back({pend_pc, imem_rdata});
                    pushed_last = 1'b1;
                    fetch_exp   = fetch_exp + 32'd1;
                end
            end
        end else if (pend && rd) begin
            pend_sq = 1'b1;
        end
        if (granted) begin
            pend     = 1'b1;
            pend_pc  = last_addr;
            pend_sq  = 1'b0;
            pend_rst = 1'b0;
        end
        prev_stall = st;
        prev_rd    = rd;
    endtask

    // Asynchronous reset pulse; any outstanding response becomes a stray one.
    task automatic doReset();
        @(negedge clk);
`ifdef IF_PERF_CNT_EN
        checkVal("fetch_cnt_pre_reset", fetch_cnt, fetch_exp);
        checkVal("squash_cnt_pre_reset", squash_cnt, squash_exp);
`endif
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        #1;
        checkVal("rst_imem_req", {31'd0, imem_req}, 32'd0);
        checkVal("rst_imem_addr", imem_addr, 32'h0000_0000);
        checkVal("rst_if_valid", {31'd0, if_valid}, 32'd0);
        checkVal("rst_if_clear", {31'd0, if_clear}, 32'd0);
        checkVal("rst_if_pc", if_pc, 32'd0);
        checkVal("rst_if_ir", if_ir, 32'd0);
`ifdef IF_PERF_CNT_EN
        checkVal("rst_fetch_cnt", fetch_cnt, 32'd0);
        checkVal("rst_squash_cnt", squash_cnt, 32'd0);
`endif
        exp_addr   = 32'h0;
        fetch_exp  = 32'h0;
        squash_exp = 32'h0;
        exp_q.delete();
        if (pend) begin
            pend_sq  = 1'b1;
            pend_rst = 1'b1;
        end
        prev_valid  = 1'b0;
        prev_stall  = 1'b0;
        prev_rd     = 1'b0;
        pushed_last = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        #1 rst_n = 1'b0;
        doReset();

        // Sequential fetch with zero-wait memory: 0, 4, 8 presented
        gnt_en = 1'b1;
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkVal("throughput_pops", 32'(pops), 32'd3);

        // Stall 5 cycles while an instruction is presented
        applyStimulus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkVal("req_after_stall", {31'd0, last_req}, 32'd1);
        checkVal("addr_after_stall", last_addr, 32'h0000_0010);

        // Redirect while waiting; late response 0xDEADBEEF must be dropped
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        hold_resp = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h0000_0100);
        hold_resp = 1'b0;
        ovr_en    = 1'b1;
        ovr_data  = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 1'b0, 32'h0);
        ovr_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkVal("redirect_wait_target", last_addr, 32'h0000_0100);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Redirect in the same cycle as the response
        applyStimulus(1'b0, 1'b1, 32'h0000_0200);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkVal("redirect_rvalid_target", last_addr, 32'h0000_0200);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Grant withheld 3 cycles, then a redirect moves the address
        gnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkVal("ungranted_req", {31'd0, last_req}, 32'd1);
            checkVal("ungranted_addr", last_addr, 32'h0000_0208);
        end
        applyStimulus(1'b0, 1'b1, 32'h0000_0300);
        gnt_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkVal("withdrawn_new_addr", last_addr, 32'h0000_0300);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Reset while waiting; the late response after release is ignored
        doReset();
        gnt_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkVal("post_reset_req", {31'd0, last_req}, 32'd1);
        checkVal("post_reset_addr", last_addr, 32'h0000_0000);
        gnt_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        gnt_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        checkVal("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef IF_PERF_CNT_EN
        checkVal("fetch_cnt_end", fetch_cnt, fetch_exp);
        checkVal("squash_cnt_end", squash_cnt, squash_exp);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
